// File: rtl/etc_fetch_scheduler.sv
// Raster-order ETC2 block fetcher: issues ROM reads under a two-entry credit budget,
// tags each read with its block coordinates and queues returned blocks for the decoder.
module etc_fetch_scheduler #(
  parameter int          ROM_LATENCY = 1,
  parameter logic [31:0] ADDR_STEP   = 32'd8
) (
  input  logic        sclk,
  input  logic        rsrt,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  blocks_x,
  input  logic [7:0]  blocks_y,
  output logic        rom_en,
  output logic [31:0] rom_addr,
  input  logic [63:0] rom_dout,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [63:0] blk_data,
  output logic [7:0]  blk_x,
  output logic [7:0]  blk_y,
  output logic        blk_last,
  output logic        busy,
  output logic        image_done,
  output logic        cfg_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       last;
  } tag_t;

  typedef struct packed {
    logic [63:0] data;
    tag_t        tag;
  } entry_t;

  state_t state, state_nxt;

  logic [7:0] cfg_x, cfg_y;
  logic [7:0] issue_x, issue_y;
  tag_t       issue_tag;
  logic       issue_last;

  // Read-latency tag pipe; stage ROM_LATENCY-1 lines up with rom_dout.
  logic [ROM_LATENCY-1:0] vld_pipe;
  logic [ROM_LATENCY:0]   vld_in;
  tag_t [ROM_LATENCY-1:0] tag_pipe;
  tag_t [ROM_LATENCY:0]   tag_in;
  logic [1:0]             in_flight;

  entry_t [1:0] buf_q;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   occ;
  logic         push, pop;
  entry_t       head;

  logic idle_like, dims_ok, start_ok, start_bad;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign dims_ok   = (blocks_x != 8'd0) && (blocks_y != 8'd0);
  assign start_ok  = idle_like && start && dims_ok;
  assign start_bad = idle_like && start && !dims_ok;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LATENCY; i++)
      in_flight = in_flight + 2'(vld_pipe[i]);
  end

  // Credit covers both queued and in-flight blocks so a returning read always has a slot.
  assign rom_en = (state == FETCH) && ((3'(occ) + 3'(in_flight)) < 3'd2);

  assign issue_last = (issue_x == cfg_x - 8'd1) && (issue_y == cfg_y - 8'd1);

  always_comb begin
    issue_tag      = '0;
    issue_tag.x    = issue_x;
    issue_tag.y    = issue_y;
    issue_tag.last = issue_last;
  end

  assign vld_in = {vld_pipe, rom_en};
  assign tag_in = {tag_pipe, issue_tag};

  assign push = vld_pipe[ROM_LATENCY-1];
  assign head = buf_q[rd_ptr];

  assign blk_valid  = (occ != 2'd0);
  assign blk_data   = head.data;
  assign blk_x      = head.tag.x;
  assign blk_y      = head.tag.y;
  assign blk_last   = head.tag.last;
  assign pop        = blk_valid && blk_ready;
  assign busy       = (state == FETCH) || (state == DRAIN);
  assign image_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = FETCH;
      FETCH:      if (rom_en && issue_last) state_nxt = DRAIN;
      DRAIN:      if (pop && head.tag.last) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) begin
      state    <= IDLE;
      cfg_x    <= '0;
      cfg_y    <= '0;
      issue_x  <= '0;
      issue_y  <= '0;
      rom_addr <= '0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= start_bad;
      if (start_ok) begin
        cfg_x    <= blocks_x;
        cfg_y    <= blocks_y;
        issue_x  <= '0;
        issue_y  <= '0;
        rom_addr <= base_addr;
      end else if (rom_en) begin
        rom_addr <= rom_addr + ADDR_STEP;
        if (issue_x == cfg_x - 8'd1) begin
          issue_x <= '0;
          issue_y <= issue_y + 8'd1;
        end else begin
          issue_x <= issue_x + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= vld_in[ROM_LATENCY-1:0];
      tag_pipe <= tag_in[ROM_LATENCY-1:0];
    end
  end

  always_ff @(posedge sclk or negedge rsrt) begin
    if (!rsrt) begin
      buf_q  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= '{data: rom_dout, tag: tag_pipe[ROM_LATENCY-1]};
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  no_push_when_full: assert property (@(posedge sclk) disable iff (!rsrt) !(push && occ == 2'd2));

endmodule

// File: tb/tb_etc_fetch_scheduler.sv
// Directed bench: one scheduler at ROM latency 1 and one at latency 3 share stimulus;
// each has its own address-tagged ROM model.
module tb_etc_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [7:0]  bx, by;
  logic        ready;

  logic        en1, vld1, last1, busy1, done1, err1;
  logic [31:0] addr1;
  logic [63:0] dout1, data1;
  logic [7:0]  x1, y1;
  logic        en3, vld3, last3, busy3, done3, err3;
  logic [31:0] addr3;
  logic [63:0] dout3, data3;
  logic [7:0]  x3, y3;
  logic [63:0] r3a, r3b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  etc_fetch_scheduler #(.ROM_LATENCY(1), .ADDR_STEP(32'd8)) u_dut1 (
    .sclk(clk), .rsrt(rst_n), .start(start), .base_addr(base), .blocks_x(bx), .blocks_y(by),
    .rom_en(en1), .rom_addr(addr1), .rom_dout(dout1), .blk_valid(vld1), .blk_ready(ready),
    .blk_data(data1), .blk_x(x1), .blk_y(y1), .blk_last(last1), .busy(busy1),
    .image_done(done1), .cfg_err(err1));

  etc_fetch_scheduler #(.ROM_LATENCY(3), .ADDR_STEP(32'd8)) u_dut3 (
    .sclk(clk), .rsrt(rst_n), .start(start), .base_addr(base), .blocks_x(bx), .blocks_y(by),
    .rom_en(en3), .rom_addr(addr3), .rom_dout(dout3), .blk_valid(vld3), .blk_ready(ready),
    .blk_data(data3), .blk_x(x3), .blk_y(y3), .blk_last(last3), .busy(busy3),
    .image_done(done3), .cfg_err(err3));

  function automatic logic [63:0] word(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, a};
  endfunction

  always @(posedge clk) begin
    dout1 <= en1 ? word(addr1) : 64'hBAD0_BAD0_BAD0_BAD0;
    r3a   <= en3 ? word(addr3) : 64'hBAD3_BAD3_BAD3_BAD3;
    r3b   <= r3a;
    dout3 <= r3b;
  end

  // Observation mux: which instance the collector watches.
  logic        sel3;
  logic        m_en, m_vld, m_last, m_done;
  logic [31:0] m_addr;
  logic [63:0] m_data;
  logic [7:0]  m_x, m_y;
  always_comb begin
    m_en   = sel3 ? en3   : en1;
    m_vld  = sel3 ? vld3  : vld1;
    m_last = sel3 ? last3 : last1;
    m_done = sel3 ? done3 : done1;
    m_addr = sel3 ? addr3 : addr1;
    m_data = sel3 ? data3 : data1;
    m_x    = sel3 ? x3    : x1;
    m_y    = sel3 ? y3    : y1;
  end

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [63:0] d;
    logic        l;
  } blk_t;

  logic [31:0] addr_q[$];
  blk_t        blk_q[$];
  int cyc, first_vld, last_cyc, done_cyc, max_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_img(input logic [31:0] b, input logic [7:0] x, input logic [7:0] y);
    addr_q.delete();
    blk_q.delete();
    first_vld = -1; last_cyc = -1; done_cyc = -1; max_out = 0;
    base = b; bx = x; by = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic sample();
    blk_t b;
    if (first_vld < 0 && m_vld) first_vld = cyc;
    if (addr_q.size() - blk_q.size() > max_out) max_out = addr_q.size() - blk_q.size();
    if (m_en) addr_q.push_back(m_addr);
    if (m_vld && ready) begin
      b.x = m_x; b.y = m_y; b.d = m_data; b.l = m_last;
      blk_q.push_back(b);
      if (m_last) last_cyc = cyc;
    end
  endtask

  task automatic collect(input int budget, input int glitch);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (m_done) begin
        done_cyc = cyc;
        got = 1'b1;
        break;
      end
      sample();
      if (cyc == glitch) begin
        base = 32'h900; bx = 8'd5; by = 8'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("image_done_seen", 64'(got), 64'd1);
  endtask

  task automatic wait_both();
    for (int i = 0; i < 100; i++) begin
      if (done1 && done3) break;
      @(negedge clk);
    end
    chk("both_done", 64'(done1 && done3), 64'd1);
  endtask

  task automatic check_image(input logic [31:0] b, input int nx, input int ny);
    int n;
    logic [31:0] a;
    n = nx * ny;
    chk("n_reads", 64'(addr_q.size()), 64'(n));
    chk("n_blocks", 64'(blk_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = b + 32'(8 * i);
      if (i < addr_q.size()) chk("rd_addr", 64'(addr_q[i]), 64'(a));
      if (i < blk_q.size()) begin
        chk("blk_x", 64'(blk_q[i].x), 64'(i % nx));
        chk("blk_y", 64'(blk_q[i].y), 64'(i / nx));
        chk("blk_data", blk_q[i].d, word(a));
        chk("blk_last", 64'(blk_q[i].l), 64'(i == n - 1));
      end
    end
  endtask

  initial begin
    logic seen_en;
    rst_n = 1'b0; start = 1'b0; base = '0; bx = '0; by = '0; ready = 1'b0; sel3 = 1'b0;
    cyc = 0; first_vld = -1; last_cyc = -1; done_cyc = -1; max_out = 0;
    repeat (2) @(negedge clk);
    chk("rst_rom_en", 64'(en1), 64'd0);
    chk("rst_rom_addr", 64'(addr1), 64'd0);
    chk("rst_blk_valid", 64'(vld1), 64'd0);
    chk("rst_blk_data", data1, 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_done", 64'(done1), 64'd0);
    chk("rst_cfg_err", 64'(err1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an image.
    ready = 1'b1;
    start_img(32'h100, 8'd2, 8'd2);
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy1), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rom_en", 64'(en1), 64'd0);
    chk("arst_blk_valid", 64'(vld1), 64'd0);
    chk("arst_rom_en3", 64'(en3), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", 64'(vld1), 64'd0);
    chk("post_rst_valid3", 64'(vld3), 64'd0);
    chk("post_rst_addr", 64'(addr1), 64'd0);
    chk("post_rst_busy", 64'(busy1), 64'd0);
    chk("post_rst_done", 64'(done1), 64'd0);

    // Zero height is rejected.
    start_img(32'h100, 8'd2, 8'd0);
    chk("cfg_err_pulse", 64'(err1), 64'd1);
    seen_en = en1;
    @(negedge clk);
    chk("cfg_err_drop", 64'(err1), 64'd0);
    for (int i = 0; i < 4; i++) begin
      seen_en = seen_en | en1;
      @(negedge clk);
    end
    chk("cfg_err_no_read", 64'(seen_en), 64'd0);
    chk("cfg_err_idle", 64'(busy1), 64'd0);
    chk("cfg_err_not_done", 64'(done1), 64'd0);

    // 2x2 image, decoder always ready.
    start_img(32'h100, 8'd2, 8'd2);
    collect(60, 0);
    check_image(32'h100, 2, 2);
    chk("first_valid_l1", 64'(first_vld), 64'd3);
    chk("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    wait_both();

    // Decoder stalled for 10 cycles.
    ready = 1'b0;
    start_img(32'h100, 8'd2, 8'd2);
    for (int i = 0; i < 10; i++) begin
      sample();
      @(negedge clk);
      cyc++;
    end
    chk("stall_reads", 64'(addr_q.size()), 64'd2);
    chk("stall_rom_en", 64'(en1), 64'd0);
    chk("stall_valid", 64'(vld1), 64'd1);
    chk("stall_data", data1, word(32'h100));
    chk("stall_x", 64'(x1), 64'd0);
    chk("stall_y", 64'(y1), 64'd0);
    ready = 1'b1;
    collect(60, 0);
    check_image(32'h100, 2, 2);
    wait_both();

    // Three-cycle ROM, 4x1 strip.
    sel3 = 1'b1;
    start_img(32'h200, 8'd4, 8'd1);
    collect(80, 0);
    check_image(32'h200, 4, 1);
    chk("first_valid_l3", 64'(first_vld), 64'd5);
    chk("max_outstanding", 64'(max_out <= 2), 64'd1);
    wait_both();
    sel3 = 1'b0;

    // Start during FETCH is ignored.
    start_img(32'h300, 8'd3, 8'd1);
    collect(60, 2);
    check_image(32'h300, 3, 1);
    wait_both();

    // Restart from DONE at base 0.
    chk("done_level", 64'(done1), 64'd1);
    start_img(32'h0, 8'd2, 8'd1);
    chk("done_drops", 64'(done1), 64'd0);
    collect(60, 0);
    check_image(32'h0, 2, 1);
    wait_both();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
